// File: rtl/fft_energy_calc.sv
// Per-bin energy (re^2 + im^2) of the FFT output stream, at most one bin every two cycles,
// with a frame-alignment check of tlast against the bin counter.
module fft_energy_calc #(
  parameter int FFT_DATA_WIDTH   = 32,
  parameter int ENRGY_DATA_WIDTH = 40,
  parameter int NUM_FFT_PTS      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [FFT_DATA_WIDTH-1:0]   s_axis_fft_tdata,
  input  logic                        s_axis_fft_tvalid,
  input  logic                        s_axis_fft_tlast,
  output logic                        s_axis_fft_tready,
  output logic [ENRGY_DATA_WIDTH-1:0] energy,
  output logic                        e_ready,
  output logic                        frame_err,
  output logic [7:0]                  bin_idx
);

  localparam int         HW       = FFT_DATA_WIDTH / 2;
  localparam int         PW       = 2 * HW;
  localparam logic [7:0] LAST_BIN = 8'(NUM_FFT_PTS - 1);

  // state  | meaning
  // HOLD   | tready low; entered out of reset and after every accept
  // ACCEPT | tready high, waiting for tvalid
  typedef enum logic {
    HOLD   = 1'b0,
    ACCEPT = 1'b1
  } in_state_e;

  in_state_e                   state_q, state_d;
  logic signed [HW-1:0]        re_q, re_d;
  logic signed [HW-1:0]        im_q, im_d;
  logic                        v1_q, v1_d;
  logic [PW-1:0]               sq_re_q, sq_re_d;
  logic [PW-1:0]               sq_im_q, sq_im_d;
  logic                        v2_q, v2_d;
  logic [ENRGY_DATA_WIDTH-1:0] energy_q, energy_d;
  logic                        e_ready_q, e_ready_d;
  logic                        frame_err_q, frame_err_d;
  logic [7:0]                  bin_cnt_q, bin_cnt_d;

  logic                        handshake;
  logic                        at_last_bin;
  logic signed [PW-1:0]        prod_re;
  logic signed [PW-1:0]        prod_im;
  logic [PW-1:0]               sum_sq;

  assign handshake   = s_axis_fft_tvalid && (state_q == ACCEPT);
  assign at_last_bin = (bin_cnt_q == LAST_BIN);

  always_comb begin
    state_d     = state_q;
    re_d        = re_q;
    im_d        = im_q;
    v1_d        = handshake;
    sq_re_d     = sq_re_q;
    sq_im_d     = sq_im_q;
    v2_d        = v1_q;
    energy_d    = energy_q;
    e_ready_d   = v2_q;
    frame_err_d = 1'b0;
    bin_cnt_d   = bin_cnt_q;
    prod_re     = re_q * re_q;
    prod_im     = im_q * im_q;
    sum_sq      = sq_re_q + sq_im_q;

    unique case (state_q)
      HOLD:   state_d = ACCEPT;
      ACCEPT: if (s_axis_fft_tvalid) state_d = HOLD;
      default: state_d = HOLD;
    endcase

    if (handshake) begin
      re_d = s_axis_fft_tdata[HW-1:0];
      im_d = s_axis_fft_tdata[FFT_DATA_WIDTH-1:HW];
      // Any tlast, expected or early, and any last bin, with or without tlast, restarts the frame.
      frame_err_d = (s_axis_fft_tlast != at_last_bin);
      bin_cnt_d   = (s_axis_fft_tlast || at_last_bin) ? 8'd0 : bin_cnt_q + 8'd1;
    end

    if (v1_q) begin
      sq_re_d = $unsigned(prod_re);
      sq_im_d = $unsigned(prod_im);
    end

    if (v2_q) begin
      energy_d = ENRGY_DATA_WIDTH'(sum_sq);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= HOLD;
      re_q        <= '0;
      im_q        <= '0;
      v1_q        <= 1'b0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      v2_q        <= 1'b0;
      energy_q    <= '0;
      e_ready_q   <= 1'b0;
      frame_err_q <= 1'b0;
      bin_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      re_q        <= re_d;
      im_q        <= im_d;
      v1_q        <= v1_d;
      sq_re_q     <= sq_re_d;
      sq_im_q     <= sq_im_d;
      v2_q        <= v2_d;
      energy_q    <= energy_d;
      e_ready_q   <= e_ready_d;
      frame_err_q <= frame_err_d;
      bin_cnt_q   <= bin_cnt_d;
    end
  end

  assign s_axis_fft_tready = (state_q == ACCEPT);
  assign energy            = energy_q;
  assign e_ready           = e_ready_q;
  assign frame_err         = frame_err_q;
  assign bin_idx           = bin_cnt_q;

endmodule

// File: tb/tb_fft_energy_calc.sv
// Bench for fft_energy_calc: directed and random bins checked every cycle against a
// transaction-level model (accept queue with due cycles, frame counter, tready alternation).
module tb_fft_energy_calc;

  localparam int N = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        s_axis_fft_tready;
  logic [39:0] energy;
  logic        e_ready;
  logic        frame_err;
  logic [7:0]  bin_idx;

  int checks = 0;
  int failures = 0;

  fft_energy_calc #(
    .FFT_DATA_WIDTH  (32),
    .ENRGY_DATA_WIDTH(40),
    .NUM_FFT_PTS     (N)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_fft_tdata (tdata),
    .s_axis_fft_tvalid(tvalid),
    .s_axis_fft_tlast (tlast),
    .s_axis_fft_tready(s_axis_fft_tready),
    .energy           (energy),
    .e_ready          (e_ready),
    .frame_err        (frame_err),
    .bin_idx          (bin_idx)
  );

  always #5 aclk = ~aclk;

  // Reference model: each accepted bin is queued with the edge at which its strobe is due.
  typedef struct {
    int          due;
    logic [39:0] e;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          n_acc = 0;
  int          last_acc = 0;
  bit          m_ready = 1'b0;
  bit          m_er = 1'b0;
  bit          m_fe = 1'b0;
  logic [39:0] m_energy = '0;
  int          m_idx = 0;
  longint      m_re, m_im;
  bit          m_at_last;
  bit          rst_seen = 1'b0;

  initial forever begin
    @(posedge aclk or negedge aresetn);
    if (!aresetn) begin
      pend.delete();
      m_ready = 1'b0; m_er = 1'b0; m_fe = 1'b0; m_energy = '0; m_idx = 0;
    end else begin
      cyc++;
      m_er = 1'b0;
      m_fe = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_er = 1'b1;
        m_energy = pend[0].e;
        void'(pend.pop_front());
      end
      if (m_ready && tvalid) begin
        m_re = longint'($signed(tdata[15:0]));
        m_im = longint'($signed(tdata[31:16]));
        m_at_last = (m_idx == N - 1);
        pend.push_back('{due: cyc + 2, e: 40'(m_re * m_re + m_im * m_im)});
        m_fe = (tlast != m_at_last);
        m_idx = (tlast || m_at_last) ? 0 : m_idx + 1;
        m_ready = 1'b0;
        n_acc++;
        last_acc = cyc;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic apply_reset();
    tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Presents one bin and returns on the falling edge after it has been accepted; tvalid stays high.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic last);
    int start;
    int waited;
    start = n_acc;
    waited = 0;
    tdata = {im, re};
    tlast = last;
    tvalid = 1'b1;
    while (n_acc == start && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    checks++;
    if (n_acc == start) begin
      failures++;
      $display("FAIL send_timeout t=%0t accepted=%0d required=%0d", $time, n_acc - start, 1);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checks += 5;
    if (s_axis_fft_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_axis_fft_tready); end
    if (energy !== 40'd0) begin failures++; $display("FAIL reset_energy got=%0d exp=0", energy); end
    if (e_ready !== 1'b0) begin failures++; $display("FAIL reset_e_ready got=%b exp=0", e_ready); end
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    if (bin_idx !== 8'd0) begin failures++; $display("FAIL reset_bin_idx got=%0d exp=0", bin_idx); end
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    checks++;
    if (s_axis_fft_tready !== 1'b1) begin failures++; $display("FAIL reset_tready_rise got=%b exp=1", s_axis_fft_tready); end
  endtask

  task automatic test_single();
    int rel;
    int n_str;
    apply_reset();
    rel = cyc;
    n_str = 0;
    fork
      begin
        send(16'd3, 16'd4, 1'b0);
        tvalid = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL single_e_ready t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL single_energy t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL single_frame_err t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL single_bin_idx t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL single_tready t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (e_ready) begin
          n_str++;
          checks += 2;
          if (cyc - last_acc !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2 edges", cyc - last_acc); end
          if (energy !== 40'd25) begin failures++; $display("FAIL single_value got=%0d exp=25", energy); end
        end
      end
    join
    checks += 3;
    if (last_acc !== rel + 2) begin failures++; $display("FAIL single_first_accept got_edge=%0d exp_edge=%0d", last_acc - rel, 2); end
    if (n_str !== 1) begin failures++; $display("FAIL single_strobes got=%0d exp=1", n_str); end
    if (bin_idx !== 8'd1) begin failures++; $display("FAIL single_bin_idx_end got=%0d exp=1", bin_idx); end
  endtask

  task automatic test_extremes();
    logic [39:0] got[$];
    apply_reset();
    fork
      begin
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h7fff, 16'h0000, 1'b0);
        tvalid = 1'b0;
      end
      for (int i = 0; i < 14; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL ext_e_ready t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL ext_energy t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL ext_frame_err t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL ext_bin_idx t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL ext_tready t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (e_ready) got.push_back(energy);
      end
    join
    checks++;
    if (got.size() !== 2) begin
      failures++; $display("FAIL ext_strobes got=%0d exp=2", got.size());
    end else begin
      checks += 2;
      if (got[0] !== 40'h0080000000) begin failures++; $display("FAIL ext_min got=%h exp=0080000000", got[0]); end
      if (got[1] !== 40'd1073676289) begin failures++; $display("FAIL ext_max got=%0d exp=1073676289", got[1]); end
    end
  endtask

  task automatic test_stream();
    int n_str;
    int prev;
    int n_fe;
    apply_reset();
    n_str = 0; prev = -1; n_fe = 0;
    fork
      begin
        for (int b = 0; b < N; b++) send(16'($urandom), 16'($urandom), b == N - 1);
        tvalid = 1'b0;
      end
      for (int i = 0; i < 50; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL stream_e_ready t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL stream_energy t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL stream_frame_err t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL stream_bin_idx t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL stream_tready t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (frame_err) n_fe++;
        if (e_ready) begin
          if (prev >= 0) begin
            checks++;
            if (cyc - prev !== 2) begin failures++; $display("FAIL stream_spacing got=%0d exp=2", cyc - prev); end
          end
          prev = cyc;
          n_str++;
        end
      end
    join
    checks += 3;
    if (n_str !== N) begin failures++; $display("FAIL stream_strobes got=%0d exp=%0d", n_str, N); end
    if (n_fe !== 0) begin failures++; $display("FAIL stream_frame_errs got=%0d exp=0", n_fe); end
    if (bin_idx !== 8'd0) begin failures++; $display("FAIL stream_bin_idx_end got=%0d exp=0", bin_idx); end
  endtask

  task automatic test_early_tlast();
    int acc5;
    int n_fe;
    int fe_cyc;
    int n_str;
    apply_reset();
    acc5 = -1; n_fe = 0; fe_cyc = -1; n_str = 0;
    fork
      begin
        for (int b = 0; b < 7; b++) begin
          send(16'($urandom), 16'($urandom), b == 5);
          if (b == 5) begin
            acc5 = last_acc;
            checks++;
            if (bin_idx !== 8'd0) begin failures++; $display("FAIL early_bin_idx_after got=%0d exp=0", bin_idx); end
          end
        end
        tvalid = 1'b0;
      end
      for (int i = 0; i < 24; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL early_e_ready t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL early_energy t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL early_frame_err t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL early_bin_idx t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL early_tready t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (frame_err) begin n_fe++; fe_cyc = cyc; end
        if (e_ready) n_str++;
      end
    join
    checks += 4;
    if (n_fe !== 1) begin failures++; $display("FAIL early_frame_errs got=%0d exp=1", n_fe); end
    if (fe_cyc !== acc5) begin failures++; $display("FAIL early_err_timing got_edge=%0d exp_edge=%0d", fe_cyc, acc5); end
    if (n_str !== 7) begin failures++; $display("FAIL early_strobes got=%0d exp=7", n_str); end
    if (bin_idx !== 8'd1) begin failures++; $display("FAIL early_bin_idx_end got=%0d exp=1", bin_idx); end
  endtask

  task automatic test_missing_tlast();
    int n_fe;
    int n_str;
    apply_reset();
    n_fe = 0; n_str = 0;
    fork
      begin
        for (int b = 0; b < 2 * N; b++) send(16'($urandom), 16'($urandom), b == 2 * N - 1);
        tvalid = 1'b0;
      end
      for (int i = 0; i < 80; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL miss_e_ready t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL miss_energy t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL miss_frame_err t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL miss_bin_idx t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL miss_tready t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (frame_err) n_fe++;
        if (e_ready) n_str++;
      end
    join
    checks += 3;
    if (n_fe !== 1) begin failures++; $display("FAIL miss_frame_errs got=%0d exp=1", n_fe); end
    if (n_str !== 2 * N) begin failures++; $display("FAIL miss_strobes got=%0d exp=%0d", n_str, 2 * N); end
    if (bin_idx !== 8'd0) begin failures++; $display("FAIL miss_bin_idx_end got=%0d exp=0", bin_idx); end
  endtask

  task automatic test_reset_mid();
    int post_str;
    apply_reset();
    post_str = 0;
    rst_seen = 1'b0;
    fork
      begin
        send(16'($urandom), 16'($urandom), 1'b0);
        send(16'($urandom), 16'($urandom), 1'b0);
        tvalid = 1'b0;
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        rst_seen = 1'b1;
        #1;
        checks += 5;
        if (s_axis_fft_tready !== 1'b0) begin failures++; $display("FAIL mid_tready got=%b exp=0", s_axis_fft_tready); end
        if (energy !== 40'd0) begin failures++; $display("FAIL mid_energy got=%0d exp=0", energy); end
        if (e_ready !== 1'b0) begin failures++; $display("FAIL mid_e_ready got=%b exp=0", e_ready); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL mid_frame_err got=%b exp=0", frame_err); end
        if (bin_idx !== 8'd0) begin failures++; $display("FAIL mid_bin_idx got=%0d exp=0", bin_idx); end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
        @(negedge aclk); #1;
        checks += 5;
        if (e_ready !== m_er) begin failures++; $display("FAIL mid_e_ready_seq t=%0t got=%b exp=%b", $time, e_ready, m_er); end
        if (energy !== m_energy) begin failures++; $display("FAIL mid_energy_seq t=%0t got=%0d exp=%0d", $time, energy, m_energy); end
        if (frame_err !== m_fe) begin failures++; $display("FAIL mid_frame_err_seq t=%0t got=%b exp=%b", $time, frame_err, m_fe); end
        if (bin_idx !== 8'(m_idx)) begin failures++; $display("FAIL mid_bin_idx_seq t=%0t got=%0d exp=%0d", $time, bin_idx, m_idx); end
        if (s_axis_fft_tready !== m_ready) begin failures++; $display("FAIL mid_tready_seq t=%0t got=%b exp=%b", $time, s_axis_fft_tready, m_ready); end
        if (rst_seen && e_ready) post_str++;
      end
    join
    checks++;
    if (post_str !== 0) begin failures++; $display("FAIL mid_post_reset_strobes got=%0d exp=0", post_str); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_stream();
    test_early_tlast();
    test_missing_tlast();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
